// File: rtl/vend_pkg.sv
// Shared vending definitions: coin codes/values used by the vend FSM and the
// change dispenser, plus the dispenser state encoding.
package vend_pkg;

  typedef enum logic [1:0] {
    COIN_NONE = 2'b00,
    COIN_5    = 2'b01,
    COIN_10   = 2'b10,
    COIN_20   = 2'b11
  } coin_e;

  localparam logic [7:0] VAL_5  = 8'd5;
  localparam logic [7:0] VAL_10 = 8'd10;
  localparam logic [7:0] VAL_20 = 8'd20;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_PULSE,
    S_GAP,
    S_FINISH
  } disp_state_e;

endpackage

// File: rtl/vend_change_dispenser_if.sv
// Payout request, refill and hopper-drive signals of the change dispenser.
interface vend_change_dispenser_if;
  logic       start;
  logic [7:0] amount;
  logic       refill;
  logic [1:0] refill_sel;
  logic [1:0] coin_out;
  logic       coin_strobe;
  logic       busy;
  logic       done;
  logic       short;
  logic [7:0] remaining;
  logic [3:0] cnt5;
  logic [3:0] cnt10;
  logic [3:0] cnt20;

  modport master (
    output start, amount, refill, refill_sel,
    input  coin_out, coin_strobe, busy, done, short, remaining, cnt5, cnt10, cnt20
  );

  modport slave (
    input  start, amount, refill, refill_sel,
    output coin_out, coin_strobe, busy, done, short, remaining, cnt5, cnt10, cnt20
  );
endinterface

// File: rtl/vend_coin_tube.sv
// One coin tube inventory: saturating 4-bit up/down counter; a refill and a
// payout in the same cycle cancel out.
module vend_coin_tube #(
  parameter int TUBE_DEPTH = 15,
  parameter int INIT_FILL  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       dec,
  output logic [3:0] cnt
);
  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && !dec) begin
      if (cnt_q < 4'(TUBE_DEPTH)) cnt_d = cnt_q + 4'd1;
    end else if (dec && !inc && cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= 4'(INIT_FILL);
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
endmodule

// File: rtl/vend_change_dispenser.sv
// Change payout engine: greedy largest-first coin selection, one timed hopper
// strobe per coin, per-denomination tube inventory and short-change flag.
module vend_change_dispenser
  import vend_pkg::*;
#(
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES   = 2,
  parameter int TUBE_DEPTH   = 15,
  parameter int INIT_FILL    = 8
) (
  input logic                   clk,
  input logic                   rst,
  vend_change_dispenser_if.slave bus
);
  disp_state_e state_q, state_d;
  coin_e       coin_q, coin_d;
  logic [7:0]  remaining_q, remaining_d;
  logic [7:0]  phase_q, phase_d;
  logic        short_q, short_d;

  // Tube index = coin code - 1 (0: 5, 1: 10, 2: 20)
  logic [2:0]       tube_inc, tube_dec;
  logic [2:0][3:0]  tube_cnt;

  for (genvar i = 0; i < 3; i++) begin : g_tube
    assign tube_inc[i] = bus.refill && (bus.refill_sel == 2'(i + 1));
    vend_coin_tube #(.TUBE_DEPTH(TUBE_DEPTH), .INIT_FILL(INIT_FILL)) u_tube (
      .clk (clk),
      .rst (rst),
      .inc (tube_inc[i]),
      .dec (tube_dec[i]),
      .cnt (tube_cnt[i])
    );
  end

  always_comb begin
    state_d     = state_q;
    coin_d      = coin_q;
    remaining_d = remaining_q;
    phase_d     = phase_q;
    short_d     = short_q;
    tube_dec    = '0;
    case (state_q)
      S_IDLE: if (bus.start) begin
        remaining_d = bus.amount;
        short_d     = 1'b0;
        state_d     = S_SELECT;
      end
      S_SELECT: begin
        state_d = S_PULSE;
        phase_d = 8'(PULSE_CYCLES - 1);
        if (remaining_q >= VAL_20 && tube_cnt[2] != 4'd0) begin
          coin_d = COIN_20; remaining_d = remaining_q - VAL_20; tube_dec[2] = 1'b1;
        end else if (remaining_q >= VAL_10 && tube_cnt[1] != 4'd0) begin
          coin_d = COIN_10; remaining_d = remaining_q - VAL_10; tube_dec[1] = 1'b1;
        end else if (remaining_q >= VAL_5 && tube_cnt[0] != 4'd0) begin
          coin_d = COIN_5;  remaining_d = remaining_q - VAL_5;  tube_dec[0] = 1'b1;
        end else begin
          // Flag is set here so it is already visible alongside done.
          state_d = S_FINISH;
          short_d = (remaining_q != 8'd0);
        end
      end
      S_PULSE: begin
        if (phase_q == 8'd0) begin
          state_d = S_GAP;
          phase_d = 8'(GAP_CYCLES - 1);
        end else begin
          phase_d = phase_q - 8'd1;
        end
      end
      S_GAP: begin
        if (phase_q == 8'd0) state_d = S_SELECT;
        else                 phase_d = phase_q - 8'd1;
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      coin_q      <= COIN_NONE;
      remaining_q <= 8'd0;
      phase_q     <= 8'd0;
      short_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      coin_q      <= coin_d;
      remaining_q <= remaining_d;
      phase_q     <= phase_d;
      short_q     <= short_d;
    end
  end

  assign bus.coin_out    = (state_q == S_PULSE) ? coin_q : COIN_NONE;
  assign bus.coin_strobe = (state_q == S_PULSE);
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.done        = (state_q == S_FINISH);
  assign bus.short       = short_q;
  assign bus.remaining   = remaining_q;
  assign bus.cnt5        = tube_cnt[0];
  assign bus.cnt10       = tube_cnt[1];
  assign bus.cnt20       = tube_cnt[2];
endmodule

// File: tb/tb_vend_change_dispenser.sv
// Directed bench for vend_change_dispenser: table of payouts plus hand-written
// refill, reset-abort and short-hold sequences.
module tb_vend_change_dispenser;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   nchk = 0;
  int   nerr = 0;

  vend_change_dispenser_if bus();

  vend_change_dispenser #(
    .PULSE_CYCLES(4), .GAP_CYCLES(2), .TUBE_DEPTH(15), .INIT_FILL(8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         do_rst;
    logic [7:0] amount;
    bit         poke;     // pulse start mid-payout
    logic [1:0] rsel;     // refill code driven into the SELECT edge of coin 1
    int         n20, n10, n5;
    logic [7:0] rem;
    bit         sh;
    logic [3:0] c5, c10, c20;
    int         lat;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int k, n20, n10, n5, ncoin, run, gap, lat;
    bit prev, ok;
    logic [1:0] last, cur;
    n20 = 0; n10 = 0; n5 = 0; ncoin = 0; run = 0; gap = 0; lat = -1;
    prev = 1'b0; ok = 1'b1; last = 2'b00; cur = 2'b00;
    if (v.do_rst) do_reset();
    @(negedge clk);
    bus.start = 1'b1; bus.amount = v.amount;
    @(negedge clk);
    bus.start = 1'b0;
    if (v.rsel != 2'b00) begin bus.refill = 1'b1; bus.refill_sel = v.rsel; end
    for (k = 1; k <= 300; k++) begin
      if (k == 2) begin bus.refill = 1'b0; bus.refill_sel = 2'b00; end
      if (v.poke && k == 5) begin bus.start = 1'b1; bus.amount = 8'd200; end
      if (v.poke && k == 6) bus.start = 1'b0;
      if (!bus.coin_strobe && bus.coin_out != 2'b00) ok = 1'b0;
      if (bus.coin_strobe && !prev) begin
        ncoin++;
        if (ncoin == 1 && k != 2) ok = 1'b0;
        if (ncoin > 1 && gap != 3) ok = 1'b0;
        if (last != 2'b00 && bus.coin_out > last) ok = 1'b0;
        last = bus.coin_out; cur = bus.coin_out; run = 1;
        case (bus.coin_out)
          2'b11:   n20++;
          2'b10:   n10++;
          2'b01:   n5++;
          default: ok = 1'b0;
        endcase
      end else if (bus.coin_strobe) begin
        run++;
        if (bus.coin_out != cur) ok = 1'b0;
      end else if (prev) begin
        if (run != 4) ok = 1'b0;
        gap = 1;
      end else begin
        gap++;
      end
      prev = bus.coin_strobe;
      if (bus.done) begin lat = k; break; end
      @(negedge clk);
    end
    if (lat < 0) $display("FAIL v%0d timeout: no done within 300 cycles", idx);
    chk($sformatf("v%0d done_latency", idx), lat, v.lat);
    chk($sformatf("v%0d strobe_protocol", idx), ok, 1);
    chk($sformatf("v%0d n20", idx), n20, v.n20);
    chk($sformatf("v%0d n10", idx), n10, v.n10);
    chk($sformatf("v%0d n5", idx), n5, v.n5);
    chk($sformatf("v%0d remaining", idx), bus.remaining, v.rem);
    chk($sformatf("v%0d short", idx), bus.short, v.sh);
    chk($sformatf("v%0d busy_with_done", idx), bus.busy, 1);
    chk($sformatf("v%0d cnt5", idx), bus.cnt5, v.c5);
    chk($sformatf("v%0d cnt10", idx), bus.cnt10, v.c10);
    chk($sformatf("v%0d cnt20", idx), bus.cnt20, v.c20);
    @(negedge clk);
    chk($sformatf("v%0d done_one_cycle", idx), bus.done, 0);
    chk($sformatf("v%0d busy_after", idx), bus.busy, 0);
    chk($sformatf("v%0d short_held", idx), bus.short, v.sh);
  endtask

  initial begin
    bit seen;
    //         rst amt  pk rsel n20 n10 n5 rem sh c5 c10 c20 lat
    vecs[0]  = '{1, 35,  0, 0,  1,  1,  1, 0,  0, 7, 7,  7,  23};
    vecs[1]  = '{1, 35,  1, 0,  1,  1,  1, 0,  0, 7, 7,  7,  23};
    vecs[2]  = '{1, 160, 0, 0,  8,  0,  0, 0,  0, 8, 8,  0,  58};
    vecs[3]  = '{0, 20,  0, 0,  0,  2,  0, 0,  0, 8, 6,  0,  16};
    vecs[4]  = '{0, 100, 0, 0,  0,  6,  8, 0,  0, 0, 0,  0,  100};
    vecs[5]  = '{0, 5,   0, 0,  0,  0,  0, 5,  1, 0, 0,  0,  2};
    vecs[6]  = '{1, 7,   0, 0,  0,  0,  1, 2,  1, 7, 8,  8,  9};
    vecs[7]  = '{0, 0,   0, 0,  0,  0,  0, 0,  0, 7, 8,  8,  2};
    vecs[8]  = '{0, 45,  0, 0,  2,  0,  1, 0,  0, 6, 8,  6,  23};
    vecs[9]  = '{1, 5,   0, 1,  0,  0,  1, 0,  0, 8, 8,  8,  9};
    vecs[10] = '{1, 255, 0, 0,  8,  8,  3, 0,  0, 5, 0,  0,  135};

    bus.start = 1'b0; bus.amount = 8'd0; bus.refill = 1'b0; bus.refill_sel = 2'b00;
    do_reset();
    chk("rst coin_out", bus.coin_out, 0);
    chk("rst coin_strobe", bus.coin_strobe, 0);
    chk("rst busy", bus.busy, 0);
    chk("rst done", bus.done, 0);
    chk("rst short", bus.short, 0);
    chk("rst remaining", bus.remaining, 0);
    chk("rst cnt5", bus.cnt5, 8);
    chk("rst cnt10", bus.cnt10, 8);
    chk("rst cnt20", bus.cnt20, 8);

    for (int i = 0; i < 11; i++) begin
      if (i == 7) begin
        repeat (3) @(negedge clk);
        chk("short_hold_idle", bus.short, 1);
        chk("remaining_hold_idle", bus.remaining, 2);
      end
      run_vec(i, vecs[i]);
    end

    // Refill saturation and refill_sel=00 no-op
    do_reset();
    bus.refill = 1'b1; bus.refill_sel = 2'b01;
    repeat (7) @(negedge clk);
    chk("refill cnt5 to 15", bus.cnt5, 15);
    @(negedge clk);
    chk("refill cnt5 saturate", bus.cnt5, 15);
    bus.refill_sel = 2'b00;
    repeat (2) @(negedge clk);
    chk("refill sel00 cnt5", bus.cnt5, 15);
    chk("refill sel00 cnt10", bus.cnt10, 8);
    chk("refill sel00 cnt20", bus.cnt20, 8);
    bus.refill_sel = 2'b11;
    @(negedge clk);
    bus.refill = 1'b0; bus.refill_sel = 2'b00;
    chk("refill cnt20 one", bus.cnt20, 9);

    // Reset in second PULSE cycle aborts with no done
    do_reset();
    @(negedge clk);
    bus.start = 1'b1; bus.amount = 8'd35;
    @(negedge clk);               // T+1: SELECT
    bus.start = 1'b0;
    @(negedge clk);               // T+2: first PULSE cycle
    chk("abort strobe_before", bus.coin_strobe, 1);
    @(negedge clk);               // T+3: second PULSE cycle
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort coin_out", bus.coin_out, 0);
    chk("abort coin_strobe", bus.coin_strobe, 0);
    chk("abort busy", bus.busy, 0);
    chk("abort remaining", bus.remaining, 0);
    chk("abort cnt20", bus.cnt20, 8);
    chk("abort cnt10", bus.cnt10, 8);
    chk("abort cnt5", bus.cnt5, 8);
    seen = 1'b0;
    for (int j = 0; j < 12; j++) begin
      if (bus.done || bus.coin_strobe || bus.busy) seen = 1'b1;
      @(negedge clk);
    end
    chk("abort quiet_after", seen, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/vend_change_dispenser.md
# vend_change_dispenser

Change payout engine for the vending machine. It takes a change amount in the same value units as the vend FSM balance and drives the coin hopper. It emits the same 2-bit coin code the vend FSM accepts on its coin input, one timed strobe per coin, using greedy largest-first selection. It also tracks a per-denomination coin-tube inventory and flags when exact change cannot be paid.

## Interface
Parameters:
- PULSE_CYCLES, 4: cycles coin_strobe is held per coin (≥1)
- GAP_CYCLES, 2: idle cycles after each coin before the next selection (≥1)
- TUBE_DEPTH, 15: tube capacity per denomination; counters are 4 bits
- INIT_FILL, 8: tube count loaded at reset (≤ TUBE_DEPTH)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  request payout; sampled only in IDLE
- amount  in  8  change to pay, unsigned value units
- refill  in  1  add one coin to the tube selected by refill_sel
- refill_sel  in  2  coin code of the refilled coin; 00 = no-op
- coin_out  out  2  coin code being paid: 01=5, 10=10, 11=20, 00 none
- coin_strobe  out  1  hopper actuate; high during PULSE
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- short  out  1  set with done if remaining ≠ 0; held until next accepted start or rst
- remaining  out  8  value still unpaid
- cnt5, cnt10, cnt20  out  4 each  tube inventories

## Operation
- States: IDLE, SELECT, PULSE, GAP, FINISH.
- IDLE, start=1: remaining←amount, short←0, go to SELECT. In any other state, start is ignored.
- SELECT (1 cycle): greedy choice, evaluated in this order:
  - remaining≥20 and cnt20>0 → 20
  - else remaining≥10 and cnt10>0 → 10
  - else remaining≥5 and cnt5>0 → 5
  - else → FINISH
- On a choice: coin_out←code, remaining←remaining−value, the chosen tube decrements, go to PULSE.
- PULSE: coin_strobe=1 and coin_out held for PULSE_CYCLES cycles, then go to GAP.
- GAP: coin_out=00, coin_strobe=0 for GAP_CYCLES cycles, then return to SELECT.
- FINISH: done=1, short←(remaining≠0), go to IDLE.
- Residue below 5 (e.g. amount not a multiple of 5) ends with short=1 and remaining = the residue.
- Refill:
  - Accepted in any state. The count saturates at TUBE_DEPTH, and a refill at capacity is dropped.
  - Refill and decrement of the same tube in the same cycle leave the count unchanged.
- Subtraction cannot underflow, because a coin is chosen only if remaining ≥ value.

## Timing
- Reset values: state IDLE, coin_out 00, coin_strobe 0, busy 0, done 0, short 0, remaining 0, all counts INIT_FILL.
- rst has priority in every state. A mid-payout reset aborts at the next edge with no done pulse; the coin in flight is already deducted and is not restored.
- Start sampled at edge T:
  - busy=1 from T+1 (SELECT).
  - First coin_strobe at T+2.
- Each coin costs 1+PULSE_CYCLES+GAP_CYCLES cycles (7 at defaults).
- After the last coin's GAP: SELECT, then FINISH. done is high exactly one cycle; busy is still 1 in that cycle and drops the cycle after.
- amount=0: SELECT at T+1, done at T+2, no strobe.
- All outputs are registered or decoded from the registered state only; there is no combinational path from inputs to outputs.

## Structure
- Package vend_pkg holds:
  - coin codes COIN_NONE/5/10/20 and their values 5/10/20, shared with the vend FSM
  - the dispenser state enum
- Sub-module vend_coin_tube, instantiated three times: a saturating 4-bit up/down counter with inc, dec, simultaneous-event rule, and reset load of INIT_FILL.
- One shared phase counter serves both PULSE and GAP, loaded on state entry.

## Test plan
- Reset, start amount=35 → coin_out 11, 10, 01 in order, each strobe 4 cycles with 2-cycle gaps; done at T+23; short=0, remaining=0; cnt20=7, cnt10=7, cnt5=7.
- amount=160 → eight 20s and cnt20=0. Then amount=20 → two 10s, cnt10=6, short=0.
- Fresh reset, amount=7 → one 5 coin; done with short=1, remaining=2. short holds until the next start.
- amount=0 → no strobe, done at T+2. A start pulsed while busy in a 35 payout → ignored, payout unchanged.
- refill_sel=01 in the same cycle SELECT picks a 5 → cnt5 unchanged. Refill into a tube at 15 → stays 15. refill_sel=00 → no change.
- rst asserted during the second cycle of PULSE → next cycle coin_out=00, coin_strobe=0, busy=0, no done, counts=8.
